// File: rtl/alu_op_issuer.sv
// -----------------------------------------------------------------------------
// alu_op_issuer
//   Initiator side of a 3-bit ALU control interface. Owns a 32x32 register
//   file, accepts MIPS R-type instruction words, drives the operands and the
//   function code to an external combinational ALU, captures its result and
//   writes it back to rd. Exactly one operation is in flight at a time.
//
//   Optional feature: define ALU_BEQ_EN to make op 6'b000100 (beq) legal.
//   The ALU then subtracts rs and rt, done pulses with the ALU result and its
//   zero flag (zero_flag = branch taken), and nothing is written back. With
//   ALU_BEQ_EN undefined, op 6'b000100 takes the error path.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   instr_valid/ready instruction handshake; instr = {op,rs,rt,rd,shamt,funct}
//   rf_we/waddr/wdata external register-file preload port (any state)
//   rf_raddr/rdata    combinational debug read; r0 reads 0
//   alu_a/b/f         registered ALU operands and function code
//   alu_y/alu_zero    ALU result and zero flag
//   done, result,     done pulses one cycle with result/zero_flag valid;
//   zero_flag         result/zero_flag hold until the next done
//   err               one-cycle pulse on an illegal instruction
//   dbg_state         current FSM state, for observation only
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready depends only on the state (IDLE), so
// it never combinationally depends on instr_valid.
// -----------------------------------------------------------------------------
module alu_op_issuer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic        rf_we,
    input  logic [4:0]  rf_waddr,
    input  logic [31:0] rf_wdata,
    input  logic [4:0]  rf_raddr,
    output logic [31:0] rf_rdata,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_f,
    input  logic [31:0] alu_y,
    input  logic        alu_zero,
    output logic        done,
    output logic [31:0] result,
    output logic        zero_flag,
    output logic        err,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // Only the fields the block uses are latched; shamt is ignored.
    logic [5:0]  r_op;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;
    logic [5:0]  r_funct;

    logic [31:0] r_rf [32];
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [2:0]  r_alu_f;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_is_beq;

    logic        w_legal;
    logic [2:0]  w_code;
    logic        w_beq;
    logic        w_unused_shamt;

    assign w_unused_shamt = ^instr[10:6];

    // Decode of the latched instruction word.
    always_comb begin
        w_legal = 1'b0;
        w_code  = 3'd0;
        w_beq   = 1'b0;
        if (r_op == 6'b000000) begin
            case (r_funct)
                6'b100100: begin w_legal = 1'b1; w_code = 3'd0; end
                6'b100101: begin w_legal = 1'b1; w_code = 3'd1; end
                6'b100000: begin w_legal = 1'b1; w_code = 3'd2; end
                6'b100010: begin w_legal = 1'b1; w_code = 3'd6; end
                6'b101010: begin w_legal = 1'b1; w_code = 3'd7; end
                default:   begin w_legal = 1'b0; w_code = 3'd0; end
            endcase
        end
`ifdef ALU_BEQ_EN
        else if (r_op == 6'b000100) begin
            w_legal = 1'b1;
            w_code  = 3'd6;
            w_beq   = 1'b1;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) w_next = S_DECODE;
            end
            S_DECODE: w_next = w_legal ? S_EXEC : S_ERR;
            S_EXEC:   w_next = S_WB;
            S_WB: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                err    = 1'b1;
                w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath and register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_funct  <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_f  <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_is_beq <= 1'b0;
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else begin
            if (r_state == S_IDLE && instr_valid) begin
                r_op    <= instr[31:26];
                r_rs    <= instr[25:21];
                r_rt    <= instr[20:16];
                r_rd    <= instr[15:11];
                r_funct <= instr[5:0];
            end
            // Operands are sampled here, so a later writeback to rs/rt (or an
            // external write in this same cycle) cannot disturb them.
            if (r_state == S_DECODE && w_legal) begin
                r_alu_a  <= r_rf[r_rs];
                r_alu_b  <= r_rf[r_rt];
                r_alu_f  <= w_code;
                r_is_beq <= w_beq;
            end
            // Captured at the end of EXEC so result/zero_flag change exactly
            // as done rises.
            if (r_state == S_EXEC) begin
                r_result <= alu_y;
                r_zero   <= alu_zero;
            end
            // External write first; the writeback below overrides it when
            // both target the same register in the same cycle.
            if (rf_we && rf_waddr != 5'd0) r_rf[rf_waddr] <= rf_wdata;
            if (r_state == S_WB && !r_is_beq && r_rd != 5'd0) r_rf[r_rd] <= r_result;
        end
    end

    assign rf_rdata  = (rf_raddr == 5'd0) ? 32'd0 : r_rf[rf_raddr];
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_f     = r_alu_f;
    assign result    = r_result;
    assign zero_flag = r_zero;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_op_issuer.sv
module tb_alu_op_issuer;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic        rf_we = 1'b0;
  logic [4:0]  rf_waddr = '0;
  logic [31:0] rf_wdata = '0;
  logic [4:0]  rf_raddr = '0;
  logic [31:0] rf_rdata;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_f;
  logic [31:0] alu_y;
  logic        alu_zero;
  logic        done, zero_flag, err;
  logic [31:0] result;
  logic [2:0]  dbg_state;

  alu_op_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_y(alu_y), .alu_zero(alu_zero),
    .done(done), .result(result), .zero_flag(zero_flag), .err(err),
    .dbg_state(dbg_state)
  );

  // Combinational ALU the block drives.
  always_comb begin
    alu_y = 32'd0;
    case (alu_f)
      3'd0: alu_y = alu_a & alu_b;
      3'd1: alu_y = alu_a | alu_b;
      3'd2: alu_y = alu_a + alu_b;
      3'd6: alu_y = alu_a - alu_b;
      3'd7: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = 32'd0;
    endcase
    alu_zero = (alu_y == 32'd0);
  end

  // Accept-edge log for throughput checks.
  int unsigned cyc = 0;
  int unsigned acc_q[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (instr_valid && instr_ready) acc_q.push_back(cyc);
  end

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rf_m [32];
  logic [31:0] last_y = 32'd0;
  logic        last_z = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [5:0] fn);
    return {op, rs, rt, rd, 5'b10101, fn};
  endfunction

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    @(negedge clk);
    rf_we = 1'b0;
    if (a != 5'd0) rf_m[a] = d;
  endtask

  task automatic rf_read(input logic [4:0] a, output logic [31:0] d);
    rf_raddr = a;
    #1;
    d = rf_rdata;
  endtask

  // Issues one instruction and returns at the negedge where done or err is
  // seen; lat counts cycles after the accept edge (1 = DECODE cycle).
  // coll_at > 0 drives an external write during that cycle.
  task automatic run_instr(input logic [31:0] iw, input int coll_at,
                           input logic [4:0] ca, input logic [31:0] cd,
                           output int lat, output logic [2:0] f2, output logic tmo);
    @(negedge clk);
    instr = iw; instr_valid = 1'b1;
    chk("ready_idle", 32'(instr_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 1; f2 = 3'd0;
    if (coll_at == 1) begin rf_we = 1'b1; rf_waddr = ca; rf_wdata = cd; end
    while (!done && !err && lat < 12) begin
      @(negedge clk);
      rf_we = 1'b0;
      lat++;
      if (lat == 2) f2 = alu_f;
      if (lat == coll_at) begin rf_we = 1'b1; rf_waddr = ca; rf_wdata = cd; end
    end
    tmo = !(done || err);
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs, rt, rd;
    logic [31:0] va, vb;
    logic        exp_err;
    logic        exp_wb;
    logic [2:0]  exp_f;
    logic [31:0] exp_y;
    logic        exp_z;
  } vec_t;

  vec_t        vecs[14];
  int          lat;
  logic [2:0]  f2;
  logic        tmo;
  logic [31:0] d, any;
  logic        seen;

  initial begin
    vecs[0]  = '{"add",      6'h00, 6'b100000, 5'd1, 5'd2, 5'd3,  32'd5,        32'd3,      1'b0, 1'b1, 3'd2, 32'd8,         1'b0};
    vecs[1]  = '{"sub_zero", 6'h00, 6'b100010, 5'd1, 5'd2, 5'd4,  32'd3,        32'd3,      1'b0, 1'b1, 3'd6, 32'd0,         1'b1};
    vecs[2]  = '{"slt_true", 6'h00, 6'b101010, 5'd2, 5'd1, 5'd5,  32'd2,        32'd3,      1'b0, 1'b1, 3'd7, 32'd1,         1'b0};
    vecs[3]  = '{"and",      6'h00, 6'b100100, 5'd1, 5'd2, 5'd6,  32'h0000f0f0, 32'h0000ff00, 1'b0, 1'b1, 3'd0, 32'h0000f000, 1'b0};
    vecs[4]  = '{"or",       6'h00, 6'b100101, 5'd1, 5'd2, 5'd7,  32'h0000f0f0, 32'h00000f0f, 1'b0, 1'b1, 3'd1, 32'h0000ffff, 1'b0};
    vecs[5]  = '{"sub_neg",  6'h00, 6'b100010, 5'd1, 5'd2, 5'd8,  32'd1,        32'd2,      1'b0, 1'b1, 3'd6, 32'hffffffff,  1'b0};
    vecs[6]  = '{"slt_false",6'h00, 6'b101010, 5'd1, 5'd2, 5'd9,  32'd5,        32'd2,      1'b0, 1'b1, 3'd7, 32'd0,         1'b1};
    vecs[7]  = '{"slt_sign", 6'h00, 6'b101010, 5'd1, 5'd2, 5'd10, 32'hffffffff, 32'd1,      1'b0, 1'b1, 3'd7, 32'd1,         1'b0};
    vecs[8]  = '{"rs_eq_rt", 6'h00, 6'b100000, 5'd1, 5'd1, 5'd11, 32'd7,        32'd7,      1'b0, 1'b1, 3'd2, 32'd14,        1'b0};
    vecs[9]  = '{"rd_eq_rs", 6'h00, 6'b100000, 5'd1, 5'd2, 5'd1,  32'd4,        32'd6,      1'b0, 1'b1, 3'd2, 32'd10,        1'b0};
    vecs[10] = '{"add_r0",   6'h00, 6'b100000, 5'd1, 5'd2, 5'd0,  32'd5,        32'd3,      1'b0, 1'b1, 3'd2, 32'd8,         1'b0};
    vecs[11] = '{"bad_funct",6'h00, 6'b000111, 5'd1, 5'd2, 5'd12, 32'd5,        32'd3,      1'b1, 1'b0, 3'd0, 32'd0,         1'b0};
    vecs[12] = '{"bad_op",   6'h01, 6'b100000, 5'd1, 5'd2, 5'd13, 32'd5,        32'd3,      1'b1, 1'b0, 3'd0, 32'd0,         1'b0};
`ifdef ALU_BEQ_EN
    vecs[13] = '{"beq",      6'h04, 6'b000000, 5'd1, 5'd2, 5'd14, 32'd7,        32'd7,      1'b0, 1'b0, 3'd6, 32'd0,         1'b1};
`else
    vecs[13] = '{"beq_ill",  6'h04, 6'b000000, 5'd1, 5'd2, 5'd14, 32'd7,        32'd7,      1'b1, 1'b0, 3'd0, 32'd0,         1'b0};
`endif
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero_flag), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_f", 32'(alu_f), 32'd0);
    rf_read(5'd5, d);
    chk("rst_rf5", d, 32'd0);

    // ---- table-driven vectors ----
    for (int i = 0; i < 14; i++) begin
      rf_write(vecs[i].rs, vecs[i].va);
      if (vecs[i].rt != vecs[i].rs) rf_write(vecs[i].rt, vecs[i].vb);
      // Marker register so error paths can prove rd is untouched.
      rf_write(vecs[i].rd, 32'h1234_0000 + 32'(i));
      if (vecs[i].rd == vecs[i].rs) rf_write(vecs[i].rs, vecs[i].va);
      run_instr(enc(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].fn),
                0, 5'd0, 32'd0, lat, f2, tmo);
      chk({vecs[i].name, "_timeout"}, 32'(tmo), 32'd0);
      if (vecs[i].exp_err) begin
        chk({vecs[i].name, "_err"}, 32'(err), 32'd1);
        chk({vecs[i].name, "_err_lat"}, 32'(lat), 32'd2);
        chk({vecs[i].name, "_no_done"}, 32'(done), 32'd0);
        chk({vecs[i].name, "_result_hold"}, result, last_y);
        chk({vecs[i].name, "_zero_hold"}, 32'(zero_flag), 32'(last_z));
      end else begin
        exp_q.push_back(vecs[i].exp_y);
        chk({vecs[i].name, "_done"}, 32'(done), 32'd1);
        chk({vecs[i].name, "_lat"}, 32'(lat), 32'd3);
        chk({vecs[i].name, "_alu_f"}, 32'(f2), 32'(vecs[i].exp_f));
        chk({vecs[i].name, "_result"}, result, exp_q.pop_front());
        chk({vecs[i].name, "_zero"}, 32'(zero_flag), 32'(vecs[i].exp_z));
        last_y = vecs[i].exp_y;
        last_z = vecs[i].exp_z;
        if (vecs[i].exp_wb && vecs[i].rd != 5'd0) rf_m[vecs[i].rd] = vecs[i].exp_y;
      end
      @(negedge clk);
      rf_we = 1'b0;
      chk({vecs[i].name, "_ready_back"}, 32'(instr_ready), 32'd1);
      chk({vecs[i].name, "_pulse_drop"}, 32'(done | err), 32'd0);
      rf_read(vecs[i].rd, d);
      chk({vecs[i].name, "_rf_rd"}, d, rf_m[vecs[i].rd]);
    end

    // ---- external write to rd during WB: writeback wins ----
    rf_write(5'd1, 32'd5);
    rf_write(5'd2, 32'd3);
    run_instr(enc(6'h00, 5'd1, 5'd2, 5'd3, 6'b100000), 3, 5'd3, 32'd9, lat, f2, tmo);
    chk("wbcoll_done", 32'(done), 32'd1);
    chk("wbcoll_result", result, 32'd8);
    rf_m[3] = 32'd8;
    @(negedge clk);
    rf_we = 1'b0;
    rf_read(5'd3, d);
    chk("wbcoll_rf3", d, 32'd8);

    // ---- external write to rs during DECODE: operand uses old value ----
    run_instr(enc(6'h00, 5'd1, 5'd2, 5'd4, 6'b100000), 1, 5'd1, 32'd100, lat, f2, tmo);
    chk("rbw_result", result, 32'd8);
    rf_m[1] = 32'd100;
    rf_m[4] = 32'd8;
    @(negedge clk);
    rf_read(5'd1, d);
    chk("rbw_rf1", d, 32'd100);
    rf_read(5'd4, d);
    chk("rbw_rf4", d, 32'd8);

    // ---- back-to-back with instr_valid held high ----
    acc_q.delete();
    @(negedge clk);
    instr = enc(6'h00, 5'd1, 5'd2, 5'd3, 6'b100000);
    instr_valid = 1'b1;
    for (int k = 0; k < 20 && acc_q.size() < 2; k++) @(negedge clk);
    instr_valid = 1'b0;
    if (acc_q.size() >= 2) chk("b2b_spacing", acc_q[1] - acc_q[0], 32'd4);
    else chk("b2b_second_accept", 32'(acc_q.size()), 32'd2);
    repeat (6) @(negedge clk);
    rf_m[3] = rf_m[1] + rf_m[2];
    rf_read(5'd3, d);
    chk("b2b_rf3", d, rf_m[3]);

    // ---- reset during EXEC ----
    rf_write(5'd1, 32'd5);
    rf_write(5'd2, 32'd3);
    @(negedge clk);
    instr = enc(6'h00, 5'd1, 5'd2, 5'd3, 6'b100000);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_exec", 32'(dbg_state), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(instr_ready), 32'd1);
    seen = 1'b0;
    repeat (2) begin @(negedge clk); seen |= done | err; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); seen |= done | err; end
    chk("rst_mid_no_pulse", 32'(seen), 32'd0);
    any = 32'd0;
    for (int i = 0; i < 32; i++) begin
      rf_read(5'(i), d);
      any |= d;
    end
    chk("rst_mid_rf_clear", any, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_ready_after", 32'(instr_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
